// File: rtl/riscv_pkg.sv
// Shared types for the memory-bus arbiter.
//   arb_state_e : arbiter FSM states (one bus transaction outstanding at a time)
//   grant_e     : which requester owns the current bus transaction
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single shared memory bus.
// Instruction fetch (read-only) and data memory (load/store) requesters
// compete; data wins by default, but after STARVE_LIMIT consecutive data
// grants with a fetch waiting, the fetch is forced through.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   if_req_i, if_addr_i            fetch request (level) and address
//   if_rdata_o, if_done_o          fetch data (held) and completion pulse
//   dm_req_i, dm_we_i, dm_strb_i,
//   dm_addr_i, dm_wdata_i          data request (level) and command
//   dm_rdata_o, dm_done_o          load data (held) and completion pulse
//   bus_req_o, bus_we_o, bus_strb_o,
//   bus_addr_o, bus_wdata_o        registered bus command
//   bus_ack_i, bus_rdata_i         bus completion and read data
//
// STARVE_LIMIT is meaningful in the range 1..15.
module mem_bus_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_strb_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_done_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_strb_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_nxt;
  grant_e           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_if, grant_dm;

  // Grants are only issued from IDLE; data wins unless fetch has starved.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (if_req_i && (!dm_req_i || (starve_cnt == CNT_MAX))) begin
        grant_if = 1'b1;
      end else if (dm_req_i) begin
        grant_dm = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acks outside BUSY_* fall through the default hold and are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_nxt = BUSY_IF;
        end else if (grant_dm) begin
          state_nxt = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus_ack_i) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture at grant time keeps the bus fields stable for the whole
  // transaction even if the requester changes or drops its inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner       <= GNT_IF;
      starve_cnt  <= '0;
      bus_we_o    <= 1'b0;
      bus_strb_o  <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if (grant_if) begin
        owner       <= GNT_IF;
        starve_cnt  <= '0;
        bus_we_o    <= 1'b0;
        bus_strb_o  <= '0;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end else if (grant_dm) begin
        owner <= GNT_DM;
        // Count only data grants that actually made a fetch wait.
        if (if_req_i && (starve_cnt != CNT_MAX)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
        bus_we_o    <= dm_we_i;
        bus_strb_o  <= dm_we_i ? dm_strb_i : '0;
        bus_addr_o  <= dm_addr_i;
        bus_wdata_o <= dm_wdata_i;
      end
      if (bus_ack_i && (state == BUSY_IF)) begin
        if_rdata_o <= bus_rdata_i;
      end
      if (bus_ack_i && (state == BUSY_DM)) begin
        dm_rdata_o <= bus_rdata_i;
      end
    end
  end

  always_comb begin
    bus_req_o = (state == BUSY_IF) || (state == BUSY_DM);
    if_done_o = (state == RESP) && (owner == GNT_IF);
    dm_done_o = (state == RESP) && (owner == GNT_DM);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each scenario pushes the bus
// transactions it expects, in expected grant order, then pops and checks
// them as the arbiter issues them.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_done_o;
  logic              dm_req_i = 1'b0;
  logic              dm_we_i = 1'b0;
  logic [STRB_W-1:0] dm_strb_i = '0;
  logic [ADDR_W-1:0] dm_addr_i = '0;
  logic [DATA_W-1:0] dm_wdata_i = '0;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_done_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [STRB_W-1:0] bus_strb_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i = 1'b0;
  logic [DATA_W-1:0] bus_rdata_i = '0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_strb_i(dm_strb_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_strb_o(bus_strb_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit                fetch;
    logic              we;
    logic [STRB_W-1:0] strb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference command model: fetches and loads carry no strobes; fetch
  // carries no write data.
  task automatic push_txn(input bit fetch, input logic we, input logic [STRB_W-1:0] strb,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] rdata);
    txn_t t;
    t.fetch = fetch;
    t.we    = fetch ? 1'b0 : we;
    t.strb  = (fetch || !we) ? '0 : strb;
    t.addr  = addr;
    t.wdata = fetch ? '0 : wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_bus_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_req_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic ack_now(input logic [DATA_W-1:0] rdata);
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    vectors++; if (bus_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_bus_req: got %b want 0", bus_req_o); end
    vectors++; if ({if_done_o, dm_done_o} !== 2'b00) begin miscompares++; $display("FAIL rst_done: got %b want 00", {if_done_o, dm_done_o}); end
    vectors++; if ({bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o} !== '0) begin miscompares++; $display("FAIL rst_cmd: got %h want 0", {bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o}); end
    vectors++; if ({if_rdata_o, dm_rdata_o} !== '0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", {if_rdata_o, dm_rdata_o}); end
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    vectors++; if (bus_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_idle_after_release: got %b want 0", bus_req_o); end
  endtask

  task automatic test_fetch_only();
    txn_t t; bit ok;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    push_txn(1'b1, 1'b0, '0, 32'h100, '0, 32'hDEADBEEF);
    tick();
    vectors++; if (bus_req_o !== 1'b1) begin miscompares++; $display("FAIL fetch_latency: bus_req got %b want 1", bus_req_o); end
    wait_bus_req(20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fetch_timeout: got no bus_req want bus_req"); end
    t = exp_q.pop_front();
    vectors++; if ({bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o} !== {t.we, t.strb, t.addr, t.wdata}) begin
      miscompares++; $display("FAIL fetch_cmd: got %h want %h", {bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o}, {t.we, t.strb, t.addr, t.wdata}); end
    tick(); tick();
    ack_now(t.rdata);
    vectors++; if ({if_done_o, dm_done_o, bus_req_o} !== 3'b100) begin miscompares++; $display("FAIL fetch_done: got %b want 100", {if_done_o, dm_done_o, bus_req_o}); end
    vectors++; if (if_rdata_o !== t.rdata) begin miscompares++; $display("FAIL fetch_rdata: got %h want %h", if_rdata_o, t.rdata); end
    if_req_i = 1'b0;
    tick();
    vectors++; if (if_done_o !== 1'b0) begin miscompares++; $display("FAIL fetch_done_width: got %b want 0", if_done_o); end
    vectors++; if (if_rdata_o !== t.rdata) begin miscompares++; $display("FAIL fetch_rdata_hold: got %h want %h", if_rdata_o, t.rdata); end
  endtask

  task automatic test_simultaneous();
    txn_t t; bit ok;
    if_req_i = 1'b1; if_addr_i = 32'h200;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_strb_i = 4'hF; dm_addr_i = 32'h2000; dm_wdata_i = 32'h12345678;
    push_txn(1'b0, 1'b1, 4'hF, 32'h2000, 32'h12345678, 32'hA5A5A5A5);
    push_txn(1'b1, 1'b0, '0, 32'h200, '0, 32'h0BADF00D);
    for (int n = 0; n < 2; n++) begin
      wait_bus_req(20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL simul_timeout[%0d]: got no bus_req want bus_req", n); end
      t = exp_q.pop_front();
      vectors++; if ({bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o} !== {t.we, t.strb, t.addr, t.wdata}) begin
        miscompares++; $display("FAIL simul_cmd[%0d]: got %h want %h", n, {bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o}, {t.we, t.strb, t.addr, t.wdata}); end
      ack_now(t.rdata);
      vectors++; if ({if_done_o, dm_done_o} !== {t.fetch, ~t.fetch}) begin
        miscompares++; $display("FAIL simul_done[%0d]: got %b want %b", n, {if_done_o, dm_done_o}, {t.fetch, ~t.fetch}); end
      vectors++; if ((t.fetch ? if_rdata_o : dm_rdata_o) !== t.rdata) begin
        miscompares++; $display("FAIL simul_rdata[%0d]: got %h want %h", n, t.fetch ? if_rdata_o : dm_rdata_o, t.rdata); end
      if (t.fetch) if_req_i = 1'b0; else dm_req_i = 1'b0;
    end
    tick();
  endtask

  task automatic test_starvation();
    txn_t t; bit ok; int j; int k;
    if_req_i = 1'b1; if_addr_i = 32'h300;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_strb_i = 4'h5; dm_addr_i = 32'h4000; dm_wdata_i = $urandom;
    k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        push_txn(1'b0, 1'b0, 4'h5, 32'h4000 + 4 * k, '0, 32'hC000_0000 + k); k++;
      end
      push_txn(1'b1, 1'b0, '0, 32'h300, '0, 32'hF000_0000 + r);
    end
    j = 0;
    for (int n = 0; n < 10; n++) begin
      wait_bus_req(20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL starve_timeout[%0d]: got no bus_req want bus_req", n); end
      t = exp_q.pop_front();
      vectors++; if ({bus_we_o, bus_strb_o, bus_addr_o} !== {t.we, t.strb, t.addr}) begin
        miscompares++; $display("FAIL starve_cmd[%0d]: got %h want %h", n, {bus_we_o, bus_strb_o, bus_addr_o}, {t.we, t.strb, t.addr}); end
      ack_now(t.rdata);
      vectors++; if ({if_done_o, dm_done_o} !== {t.fetch, ~t.fetch}) begin
        miscompares++; $display("FAIL starve_done[%0d]: got %b want %b", n, {if_done_o, dm_done_o}, {t.fetch, ~t.fetch}); end
      vectors++; if ((t.fetch ? if_rdata_o : dm_rdata_o) !== t.rdata) begin
        miscompares++; $display("FAIL starve_rdata[%0d]: got %h want %h", n, t.fetch ? if_rdata_o : dm_rdata_o, t.rdata); end
      if (!t.fetch) begin j++; dm_addr_i = 32'h4000 + 4 * j; dm_wdata_i = $urandom; end
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    tick();
  endtask

  task automatic test_stability();
    txn_t t; bit ok;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_strb_i = 4'h3; dm_addr_i = 32'h5000; dm_wdata_i = 32'hCAFEF00D;
    push_txn(1'b0, 1'b1, 4'h3, 32'h5000, 32'hCAFEF00D, 32'h13572468);
    wait_bus_req(20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stable_timeout: got no bus_req want bus_req"); end
    t = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      vectors++; if ({bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o, dm_done_o} !== {1'b1, t.we, t.strb, t.addr, t.wdata, 1'b0}) begin
        miscompares++; $display("FAIL stable_cmd[%0d]: got %h want %h", i, {bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o, dm_done_o},
                                {1'b1, t.we, t.strb, t.addr, t.wdata, 1'b0}); end
      // Requester walks away mid-transaction; the transfer must still finish.
      if (i == 3) begin dm_req_i = 1'b0; dm_addr_i = 32'hFFFF_0000; dm_wdata_i = '1; dm_strb_i = 4'hC; dm_we_i = 1'b0; end
      tick();
    end
    ack_now(t.rdata);
    vectors++; if ({dm_done_o, dm_rdata_o} !== {1'b1, t.rdata}) begin
      miscompares++; $display("FAIL stable_done: got %h want %h", {dm_done_o, dm_rdata_o}, {1'b1, t.rdata}); end
    tick();
    vectors++; if ({dm_done_o, if_done_o, bus_req_o} !== 3'b000) begin miscompares++; $display("FAIL stable_single_pulse: got %b want 000", {dm_done_o, if_done_o, bus_req_o}); end
  endtask

  task automatic test_spurious_ack();
    logic [DATA_W-1:0] if_hold, dm_hold;
    txn_t t;
    if_hold = if_rdata_o; dm_hold = dm_rdata_o;
    ack_now(32'hBADBAD00);
    vectors++; if ({if_done_o, dm_done_o, bus_req_o} !== 3'b000) begin miscompares++; $display("FAIL spur_outputs: got %b want 000", {if_done_o, dm_done_o, bus_req_o}); end
    vectors++; if ({if_rdata_o, dm_rdata_o} !== {if_hold, dm_hold}) begin miscompares++; $display("FAIL spur_rdata: got %h want %h", {if_rdata_o, dm_rdata_o}, {if_hold, dm_hold}); end
    if_req_i = 1'b1; if_addr_i = 32'h800;
    push_txn(1'b1, 1'b0, '0, 32'h800, '0, 32'h2468ACE0);
    tick();
    t = exp_q.pop_front();
    vectors++; if ({bus_req_o, bus_addr_o} !== {1'b1, t.addr}) begin miscompares++; $display("FAIL spur_still_idle: got %h want %h", {bus_req_o, bus_addr_o}, {1'b1, t.addr}); end
    ack_now(t.rdata);
    vectors++; if ({if_done_o, if_rdata_o} !== {1'b1, t.rdata}) begin miscompares++; $display("FAIL spur_followup: got %h want %h", {if_done_o, if_rdata_o}, {1'b1, t.rdata}); end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    txn_t t; bit ok;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_strb_i = '0; dm_addr_i = 32'h6000; dm_wdata_i = '0;
    push_txn(1'b0, 1'b0, '0, 32'h6000, '0, 32'h11111111);
    wait_bus_req(20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_timeout: got no bus_req want bus_req"); end
    t = exp_q.pop_front();
    vectors++; if (bus_addr_o !== t.addr) begin miscompares++; $display("FAIL rmid_addr: got %h want %h", bus_addr_o, t.addr); end
    tick();
    #2 rst_ni = 1'b0;
    #1;
    vectors++; if ({bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o, if_done_o, dm_done_o, if_rdata_o, dm_rdata_o} !== '0) begin
      miscompares++; $display("FAIL rmid_outputs_zero: got %h want 0", {bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o, if_done_o, dm_done_o, if_rdata_o, dm_rdata_o}); end
    tick();
    ack_now(t.rdata);
    dm_req_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({dm_done_o, if_done_o, bus_req_o} !== 3'b000) begin miscompares++; $display("FAIL rmid_no_done[%0d]: got %b want 000", i, {dm_done_o, if_done_o, bus_req_o}); end
    end
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_strb_i = 4'h8; dm_addr_i = 32'h7000; dm_wdata_i = 32'h89ABCDEF;
    push_txn(1'b0, 1'b1, 4'h8, 32'h7000, 32'h89ABCDEF, 32'h0);
    tick();
    t = exp_q.pop_front();
    vectors++; if ({bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o} !== {1'b1, t.we, t.strb, t.addr, t.wdata}) begin
      miscompares++; $display("FAIL rmid_regrant: got %h want %h", {bus_req_o, bus_we_o, bus_strb_o, bus_addr_o, bus_wdata_o}, {1'b1, t.we, t.strb, t.addr, t.wdata}); end
    ack_now(t.rdata);
    vectors++; if (dm_done_o !== 1'b1) begin miscompares++; $display("FAIL rmid_regrant_done: got %b want 1", dm_done_o); end
    dm_req_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_stability();
    test_spurious_ack();
    test_reset_mid();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all ports SHALL be ADDR_W.
REQ-002 Parameter DATA_W, 32, data width; strobe width SHALL be DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive dmem grants with fetch pending before fetch SHALL be forced; legal range 1-15.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 if_req_i  in  1  fetch read request, level, held until if_done_o.
REQ-008 if_addr_i  in  ADDR_W  fetch address.
REQ-009 if_rdata_o  out  DATA_W  fetch read data, valid while if_done_o=1.
REQ-010 if_done_o  out  1  one-cycle fetch completion pulse.
REQ-011 dm_req_i  in  1  data request, level, held until dm_done_o.
REQ-012 dm_we_i  in  1  1 = store, 0 = load.
REQ-013 dm_strb_i  in  DATA_W/8  store byte enables.
REQ-014 dm_addr_i  in  ADDR_W  data address.
REQ-015 dm_wdata_i  in  DATA_W  store data.
REQ-016 dm_rdata_o  out  DATA_W  load data, valid while dm_done_o=1.
REQ-017 dm_done_o  out  1  one-cycle data completion pulse; drives hazard control's mem-done input.
REQ-018 bus_req_o  out  1  shared bus request, held until bus_ack_i.
REQ-019 bus_we_o / bus_strb_o / bus_addr_o / bus_wdata_o  out  1 / DATA_W/8 / ADDR_W / DATA_W  registered command fields.
REQ-020 bus_ack_i  in  1  bus completion, one cycle, only while bus_req_o=1.
REQ-021 bus_rdata_i  in  DATA_W  read data, valid with bus_ack_i.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM, RESP; exactly one bus transaction outstanding.
REQ-023 IDLE: no request -> stay; request(s) -> capture winner's command into bus registers, bus_req_o=1 next cycle, go BUSY_IF or BUSY_DM.
REQ-024 Winner: dm_req_i wins over if_req_i unless starve counter == STARVE_LIMIT and if_req_i=1, then fetch wins.
REQ-025 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each dmem grant while if_req_i=1, clear on each fetch grant, otherwise hold.
REQ-026 Fetch command SHALL drive bus_we_o=0, bus_strb_o=0, bus_wdata_o=0.
REQ-027 Load command SHALL drive bus_strb_o=0; store SHALL pass dm_strb_i unchanged.
REQ-028 BUSY_*: bus command fields SHALL stay stable; on bus_ack_i, drop bus_req_o next cycle, register bus_rdata_i into the owner's rdata, go RESP.
REQ-029 RESP: owner's done_o=1 for exactly this cycle; next state IDLE; no new grant issued in RESP.
REQ-030 Latency: request seen in IDLE at cycle 0, ack at cycle k (k>=1) -> done at k+1, next grant evaluated at k+2.
REQ-031 Requester dropping req mid-transaction SHALL NOT abort; transaction completes and done still pulses.
REQ-032 bus_ack_i outside BUSY_* SHALL be ignored with no state change.
REQ-033 if_rdata_o / dm_rdata_o SHALL hold last captured value between completions.

Reset
REQ-034 While rst_ni=0: state IDLE, starve counter 0, all outputs 0, independent of clk_i.
REQ-035 Reset asserted mid-transaction SHALL discard it; no done pulse after release; first grant earliest one cycle after rst_ni rises with a request present.

Structure
REQ-036 State enum arb_state_e and grant-owner encoding SHALL live in riscv_pkg.
REQ-037 Single module; no sub-module; counter width $clog2(STARVE_LIMIT+1).

Verification
REQ-038 Fetch only: if_req_i=1 addr 0x100, ack 2 cycles after bus_req_o with rdata 0xDEADBEEF -> bus_addr_o=0x100, bus_we_o=0, if_done_o one cycle with if_rdata_o=0xDEADBEEF.
REQ-039 Simultaneous: if_req_i and dm_req_i (store 0x2000, strb 0xF, wdata 0x12345678) same cycle -> dmem granted first with exact fields, fetch granted after dm_done_o.
REQ-040 Starvation: if_req_i held, dm_req_i re-asserted continuously, STARVE_LIMIT=4 -> 4 dmem grants then fetch granted, counter returns to 0.
REQ-041 Stability: ack delayed 10 cycles -> bus command fields unchanged throughout, exactly one done pulse.
REQ-042 Reset mid-transaction: rst_ni low during BUSY_DM -> all outputs 0 immediately, no dm_done_o after release.
REQ-043 Spurious ack in IDLE -> no done pulse, no state change.
